// File: rtl/gem_tx_link_ctrl_if.sv
// rtl/gem_tx_link_ctrl_if.sv - GEM trigger TX link controller signal bundle
interface gem_tx_link_ctrl_if;
  logic       TRG_TX_PLL_LOCK;
  logic       TX_SYNC_DONE;
  logic       TX_SEL;
  logic       TEST_REQ;
  logic       RESYNC_REQ;
  logic       TRG_RST;
  logic       ENA_TEST_PAT;
  logic       LINK_READY;
  logic [2:0] STATE;
  logic [7:0] RESYNC_CNT;
  logic       TRAIN_DONE;

  modport master (
    output TRG_TX_PLL_LOCK, TX_SYNC_DONE, TX_SEL, TEST_REQ, RESYNC_REQ,
    input  TRG_RST, ENA_TEST_PAT, LINK_READY, STATE, RESYNC_CNT, TRAIN_DONE
  );

  modport slave (
    input  TRG_TX_PLL_LOCK, TX_SYNC_DONE, TX_SEL, TEST_REQ, RESYNC_REQ,
    output TRG_RST, ENA_TEST_PAT, LINK_READY, STATE, RESYNC_CNT, TRAIN_DONE
  );
endinterface

// File: rtl/gem_tx_link_ctrl.sv
// rtl/gem_tx_link_ctrl.sv - GEM trigger fiber TX bring-up and run-time link sequencer
module gem_tx_link_ctrl #(
  parameter int LOCK_WAIT    = 1024,
  parameter int TRAIN_FRAMES = 64,
  parameter bit SIM_SPEEDUP  = 1'b0
) (
  input logic               TRG_CLK80,
  input logic               TRG_TXRESETDONE,
  gem_tx_link_ctrl_if.slave link
);

  localparam int LOCK_WAIT_EFF = SIM_SPEEDUP ? 16 : LOCK_WAIT;
  localparam int TRAIN_CYCLES  = 2 * (SIM_SPEEDUP ? 4 : TRAIN_FRAMES);
  localparam int LOCK_CW       = $clog2(LOCK_WAIT_EFF + 1);
  localparam int TRAIN_CW      = $clog2(TRAIN_CYCLES + 1);

  localparam logic [LOCK_CW-1:0]  LOCK_LAST  = LOCK_CW'(LOCK_WAIT_EFF - 1);
  localparam logic [TRAIN_CW-1:0] TRAIN_LAST = TRAIN_CW'(TRAIN_CYCLES - 1);
  localparam logic [LOCK_CW-1:0]  LOCK_ONE   = LOCK_CW'(1);
  localparam logic [TRAIN_CW-1:0] TRAIN_ONE  = TRAIN_CW'(1);

  localparam logic [2:0] ST_RESET = 3'd0;
  localparam logic [2:0] ST_LOCK  = 3'd1;
  localparam logic [2:0] ST_SYNC  = 3'd2;
  localparam logic [2:0] ST_TRAIN = 3'd3;
  localparam logic [2:0] ST_RUN   = 3'd4;

  logic [2:0]          state_q, state_d;
  logic [LOCK_CW-1:0]  lock_cnt_q, lock_cnt_d;
  logic [TRAIN_CW-1:0] train_cnt_q, train_cnt_d;
  logic                trg_rst_q, trg_rst_d;
  logic                ena_test_pat_q, ena_test_pat_d;
  logic                link_ready_q, link_ready_d;
  logic [7:0]          resync_cnt_q, resync_cnt_d;
  logic                train_done_q, train_done_d;
  logic                retrain_evt;

  always_comb begin
    state_d     = state_q;
    lock_cnt_d  = lock_cnt_q;
    train_cnt_d = train_cnt_q;
    retrain_evt = 1'b0;

    case (state_q)
      ST_RESET: begin
        state_d    = ST_LOCK;
        lock_cnt_d = '0;
      end
      ST_LOCK: begin
        if (!link.TRG_TX_PLL_LOCK) begin
          lock_cnt_d = '0;
        end else if (lock_cnt_q == LOCK_LAST) begin
          state_d = ST_SYNC;
        end else begin
          lock_cnt_d = lock_cnt_q + LOCK_ONE;
        end
      end
      ST_SYNC: begin
        if (!link.TRG_TX_PLL_LOCK) begin
          state_d    = ST_LOCK;
          lock_cnt_d = '0;
        end else if (link.TX_SYNC_DONE) begin
          state_d     = ST_TRAIN;
          train_cnt_d = '0;
        end
      end
      ST_TRAIN, ST_RUN: begin
        // Exit conditions are prioritised so coincident causes yield one event.
        if (!link.TRG_TX_PLL_LOCK) begin
          state_d     = ST_LOCK;
          lock_cnt_d  = '0;
          retrain_evt = 1'b1;
        end else if (!link.TX_SYNC_DONE) begin
          state_d     = ST_SYNC;
          retrain_evt = 1'b1;
        end else if (state_q == ST_RUN) begin
          if (link.RESYNC_REQ) begin
            state_d     = ST_TRAIN;
            train_cnt_d = '0;
            retrain_evt = 1'b1;
          end
        end else if (train_cnt_q == TRAIN_LAST) begin
          state_d = ST_RUN;
        end else begin
          train_cnt_d = train_cnt_q + TRAIN_ONE;
        end
      end
      default: begin
        state_d = ST_RESET;
      end
    endcase
  end

  always_comb begin
    ena_test_pat_d = ena_test_pat_q;
    // In RUN only sample on second-word edges so the next frame starts clean.
    if ((state_q != ST_RUN) || !link.TX_SEL) begin
      ena_test_pat_d = link.TEST_REQ;
    end

    resync_cnt_d = resync_cnt_q;
    if (retrain_evt && (resync_cnt_q != 8'hFF)) begin
      resync_cnt_d = resync_cnt_q + 8'd1;
    end

    trg_rst_d    = (state_d != ST_RUN);
    link_ready_d = (state_d == ST_RUN);
    train_done_d = (state_q == ST_TRAIN) && (state_d == ST_RUN);
  end

  always_ff @(posedge TRG_CLK80 or negedge TRG_TXRESETDONE) begin
    if (!TRG_TXRESETDONE) begin
      state_q        <= ST_RESET;
      lock_cnt_q     <= '0;
      train_cnt_q    <= '0;
      trg_rst_q      <= 1'b1;
      ena_test_pat_q <= 1'b0;
      link_ready_q   <= 1'b0;
      resync_cnt_q   <= 8'd0;
      train_done_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      lock_cnt_q     <= lock_cnt_d;
      train_cnt_q    <= train_cnt_d;
      trg_rst_q      <= trg_rst_d;
      ena_test_pat_q <= ena_test_pat_d;
      link_ready_q   <= link_ready_d;
      resync_cnt_q   <= resync_cnt_d;
      train_done_q   <= train_done_d;
    end
  end

  assign link.STATE        = state_q;
  assign link.TRG_RST      = trg_rst_q;
  assign link.ENA_TEST_PAT = ena_test_pat_q;
  assign link.LINK_READY   = link_ready_q;
  assign link.RESYNC_CNT   = resync_cnt_q;
  assign link.TRAIN_DONE   = train_done_q;

endmodule

// File: tb/tb_gem_tx_link_ctrl.sv
// tb/tb_gem_tx_link_ctrl.sv - self-checking bench for gem_tx_link_ctrl
module tb_gem_tx_link_ctrl;

  localparam int LW        = 16;
  localparam int TRAIN_CYC = 8;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  bit   mon_en   = 1'b0;
  bit   phase    = 1'b1;

  gem_tx_link_ctrl_if bus();

  gem_tx_link_ctrl #(
    .LOCK_WAIT    (1024),
    .TRAIN_FRAMES (64),
    .SIM_SPEEDUP  (1'b1)
  ) dut (
    .TRG_CLK80       (clk),
    .TRG_TXRESETDONE (rstn),
    .link            (bus)
  );

  always #6 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model: states by name, counters as "cycles spent" in each phase.
  int m_state    = 0;
  int m_lock_run = 0;
  int m_train_run = 0;
  int m_cnt      = 0;
  bit m_ena      = 1'b0;
  bit m_done     = 1'b0;

  task automatic model_step();
    int nxt;
    if (!rstn) begin
      m_state = 0; m_lock_run = 0; m_train_run = 0; m_cnt = 0; m_ena = 0; m_done = 0;
      return;
    end
    nxt    = m_state;
    m_done = 1'b0;
    if (!(m_state == 4 && bus.TX_SEL)) m_ena = bus.TEST_REQ;
    case (m_state)
      0: nxt = 1;
      1: begin
        if (bus.TRG_TX_PLL_LOCK) begin
          m_lock_run++;
          if (m_lock_run == LW) nxt = 2;
        end else begin
          m_lock_run = 0;
        end
      end
      2: begin
        if (!bus.TRG_TX_PLL_LOCK) nxt = 1;
        else if (bus.TX_SYNC_DONE) nxt = 3;
      end
      3, 4: begin
        if (!bus.TRG_TX_PLL_LOCK) nxt = 1;
        else if (!bus.TX_SYNC_DONE) nxt = 2;
        else if (m_state == 4 && bus.RESYNC_REQ) nxt = 3;
        else if (m_state == 3) begin
          m_train_run++;
          if (m_train_run == TRAIN_CYC) begin
            nxt    = 4;
            m_done = 1'b1;
          end
        end
      end
      default: nxt = 0;
    endcase
    if ((m_state == 3 || m_state == 4) && !(m_state == 3 && nxt == 3) && !(m_state == 3 && nxt == 4)
        && !(m_state == 4 && nxt == 4))
      m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
    if (nxt == 1 && m_state != 1) m_lock_run = 0;
    if (nxt == 3 && m_state != 3) m_train_run = 0;
    m_state = nxt;
  endtask

  initial forever begin
    @(posedge clk or negedge rstn);
    model_step();
  end

  function automatic logic [14:0] model_vec();
    return {3'(m_state), (m_state != 4), m_ena, (m_state == 4), 8'(m_cnt), m_done};
  endfunction

  function automatic logic [14:0] dut_vec();
    return {bus.STATE, bus.TRG_RST, bus.ENA_TEST_PAT, bus.LINK_READY, bus.RESYNC_CNT, bus.TRAIN_DONE};
  endfunction

  initial forever begin
    @(negedge clk);
    if (mon_en) chk("model", 32'(dut_vec()), 32'(model_vec()));
  end

  task automatic cyc(input bit l, input bit s, input bit sel, input bit t, input bit r);
    @(negedge clk);
    bus.TRG_TX_PLL_LOCK = l;
    bus.TX_SYNC_DONE    = s;
    bus.TX_SEL          = sel;
    bus.TEST_REQ        = t;
    bus.RESYNC_REQ      = r;
    @(posedge clk);
    #1;
  endtask

  task automatic step(input bit l, input bit s, input bit t, input bit r);
    cyc(l, s, phase, t, r);
    phase = ~phase;
  endtask

  task automatic bring_up(input string tag, input bit t);
    int n = 0;
    while (bus.STATE != 3'd4 && n < 100) begin
      step(1, 1, t, 0);
      n++;
    end
    chk({tag, "_reach_run"}, 32'(bus.STATE), 32'd4);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  typedef struct {
    bit l, s, sel, t, r;
    int st;
    bit ena;
    int cnt;
    bit done;
  } vec_t;

  function automatic vec_t mk(input bit l, input bit s, input bit sel, input bit t, input bit r,
                              input int st, input bit ena, input int cnt, input bit done);
    vec_t v;
    v.l = l; v.s = s; v.sel = sel; v.t = t; v.r = r;
    v.st = st; v.ena = ena; v.cnt = cnt; v.done = done;
    return v;
  endfunction

  initial begin
    #3000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    bit   treq;
    // From RUN: frame-aligned PRBS switching, retrain, exit counting.
    tbl.push_back(mk(1,1,1,0,0, 4,0,0,0));
    tbl.push_back(mk(1,1,0,0,0, 4,0,0,0));
    tbl.push_back(mk(1,1,1,1,0, 4,0,0,0));
    tbl.push_back(mk(1,1,0,1,0, 4,1,0,0));
    tbl.push_back(mk(1,1,1,0,0, 4,1,0,0));
    tbl.push_back(mk(1,1,0,0,0, 4,0,0,0));
    tbl.push_back(mk(1,1,1,1,0, 4,0,0,0));
    tbl.push_back(mk(1,1,0,0,0, 4,0,0,0));
    tbl.push_back(mk(1,1,1,0,1, 3,0,1,0));
    tbl.push_back(mk(1,1,0,0,0, 3,0,1,0));
    tbl.push_back(mk(1,1,1,0,1, 3,0,1,0));
    tbl.push_back(mk(1,1,0,0,0, 3,0,1,0));
    tbl.push_back(mk(1,1,1,0,0, 3,0,1,0));
    tbl.push_back(mk(1,1,0,0,0, 3,0,1,0));
    tbl.push_back(mk(1,1,1,0,0, 3,0,1,0));
    tbl.push_back(mk(1,1,0,0,0, 3,0,1,0));
    tbl.push_back(mk(1,1,1,0,0, 4,0,1,1));
    tbl.push_back(mk(1,1,0,0,0, 4,0,1,0));
    tbl.push_back(mk(1,1,1,0,0, 4,0,1,0));
    tbl.push_back(mk(1,0,0,0,0, 2,0,2,0));
    tbl.push_back(mk(1,1,1,0,0, 3,0,2,0));
    tbl.push_back(mk(1,0,0,0,0, 2,0,3,0));
    tbl.push_back(mk(0,0,1,0,0, 1,0,3,0));

    bus.TRG_TX_PLL_LOCK = 1'b1;
    bus.TX_SYNC_DONE    = 1'b1;
    bus.TX_SEL          = 1'b1;
    bus.TEST_REQ        = 1'b0;
    bus.RESYNC_REQ      = 1'b0;
    #1 rstn = 1'b0;
    #1 mon_en = 1'b1;

    // Reset values and bring-up timing.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", 32'(bus.STATE), 32'd0);
    chk("rst_trg_rst", 32'(bus.TRG_RST), 32'd1);
    chk("rst_ena", 32'(bus.ENA_TEST_PAT), 32'd0);
    chk("rst_ready", 32'(bus.LINK_READY), 32'd0);
    chk("rst_cnt", 32'(bus.RESYNC_CNT), 32'd0);
    chk("rst_done", 32'(bus.TRAIN_DONE), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    chk("t1_lock_entry", 32'(bus.STATE), 32'd1);
    repeat (LW - 1) step(1, 1, 0, 0);
    chk("t1_still_lock", 32'(bus.STATE), 32'd1);
    step(1, 1, 0, 0);
    chk("t1_sync", 32'(bus.STATE), 32'd2);
    step(1, 1, 0, 0);
    chk("t1_train", 32'(bus.STATE), 32'd3);
    repeat (TRAIN_CYC - 1) step(1, 1, 0, 0);
    chk("t1_still_train", 32'(bus.STATE), 32'd3);
    chk("t1_train_rst", 32'(bus.TRG_RST), 32'd1);
    step(1, 1, 0, 0);
    chk("t1_run", 32'(bus.STATE), 32'd4);
    chk("t1_done_pulse", 32'(bus.TRAIN_DONE), 32'd1);
    chk("t1_rst_fall", 32'(bus.TRG_RST), 32'd0);
    chk("t1_ready_rise", 32'(bus.LINK_READY), 32'd1);
    step(1, 1, 0, 0);
    chk("t1_done_end", 32'(bus.TRAIN_DONE), 32'd0);
    chk("t1_cnt", 32'(bus.RESYNC_CNT), 32'd0);

    foreach (tbl[i]) begin
      cyc(tbl[i].l, tbl[i].s, tbl[i].sel, tbl[i].t, tbl[i].r);
      chk($sformatf("tbl%0d_state", i), 32'(bus.STATE), 32'(tbl[i].st));
      chk($sformatf("tbl%0d_trg_rst", i), 32'(bus.TRG_RST), 32'(tbl[i].st != 4));
      chk($sformatf("tbl%0d_ready", i), 32'(bus.LINK_READY), 32'(tbl[i].st == 4));
      chk($sformatf("tbl%0d_ena", i), 32'(bus.ENA_TEST_PAT), 32'(tbl[i].ena));
      chk($sformatf("tbl%0d_cnt", i), 32'(bus.RESYNC_CNT), 32'(tbl[i].cnt));
      chk($sformatf("tbl%0d_done", i), 32'(bus.TRAIN_DONE), 32'(tbl[i].done));
    end

    // Lock glitch at count 10 restarts the stable-lock wait.
    do_reset();
    @(posedge clk);
    #1;
    chk("t2_lock_entry", 32'(bus.STATE), 32'd1);
    repeat (10) step(1, 1, 0, 0);
    step(0, 1, 0, 0);
    chk("t2_glitch_lock", 32'(bus.STATE), 32'd1);
    repeat (LW - 1) step(1, 1, 0, 0);
    chk("t2_restart_lock", 32'(bus.STATE), 32'd1);
    step(1, 1, 0, 0);
    chk("t2_sync", 32'(bus.STATE), 32'd2);

    // Randomised traffic against the model.
    treq = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 7) == 0) treq = ~treq;
      step(($urandom_range(0, 63) != 0), ($urandom_range(0, 31) != 0), treq,
           ($urandom_range(0, 39) == 0));
    end

    // Coincident lock+sync loss from RUN, and counter saturation.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      bring_up("sat", 1'b0);
      step(0, 0, 0, 0);
      chk("sat_state", 32'(bus.STATE), 32'd1);
      chk("sat_cnt", 32'(bus.RESYNC_CNT), (i + 1 > 255) ? 32'd255 : 32'(i + 1));
    end

    // Asynchronous reset mid-TRAIN.
    begin
      int n = 0;
      while (bus.STATE != 3'd3 && n < 100) begin
        step(1, 1, 1, 0);
        n++;
      end
    end
    step(1, 1, 1, 0);
    chk("t6_pre_state", 32'(bus.STATE), 32'd3);
    chk("t6_pre_ena", 32'(bus.ENA_TEST_PAT), 32'd1);
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("t6_async_state", 32'(bus.STATE), 32'd0);
    chk("t6_async_trg_rst", 32'(bus.TRG_RST), 32'd1);
    chk("t6_async_ena", 32'(bus.ENA_TEST_PAT), 32'd0);
    chk("t6_async_ready", 32'(bus.LINK_READY), 32'd0);
    chk("t6_async_cnt", 32'(bus.RESYNC_CNT), 32'd0);
    chk("t6_async_done", 32'(bus.TRAIN_DONE), 32'd0);

    // Illegal state code recovers through RESET.
    @(negedge clk);
    rstn = 1'b1;
    bring_up("ill", 1'b0);
    mon_en = 1'b0;
    @(negedge clk);
    force dut.state_q = 3'd6;
    @(posedge clk);
    #1;
    chk("ill_trg_rst", 32'(bus.TRG_RST), 32'd1);
    chk("ill_ready", 32'(bus.LINK_READY), 32'd0);
    release dut.state_q;
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
